// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl_pkg: shared state encoding, field limits and default timing for the clock setter
package clock_set_ctrl_pkg;
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, COMMIT} state_e;
  typedef logic [4:0] hours_t;
  typedef logic [5:0] minutes_t;
  localparam hours_t   HOURS_MAX        = 5'd23;
  localparam minutes_t MINUTES_MAX      = 6'd59;
  localparam int       DEF_HALF_SEC     = 24999999;
  localparam int       DEF_DEBOUNCE_CYC = 1000000;
  localparam int       DEF_TIMEOUT_S    = 30;
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: button, timekeeper and display signals of the clock setter
interface clock_set_ctrl_if;
  import clock_set_ctrl_pkg::*;
  logic     btn_mode;
  logic     btn_inc;
  hours_t   cur_hours;
  minutes_t cur_minutes;
  logic     hold;
  logic     load;
  hours_t   new_hours;
  minutes_t new_minutes;
  logic [3:0] digit_blank;
  modport master (output btn_mode, btn_inc, cur_hours, cur_minutes,
                  input  hold, load, new_hours, new_minutes, digit_blank);
  modport slave  (input  btn_mode, btn_inc, cur_hours, cur_minutes,
                  output hold, load, new_hours, new_minutes, digit_blank);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus a level filter needing DEBOUNCE_CYC equal samples
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYC - 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  // count consecutive samples that disagree with the accepted level; adopt on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= (sync_q[1] == level_q || cnt_q == CMAX) ? '0 : cnt_q + 1'b1;
      level_q <= (sync_q[1] != level_q && cnt_q == CMAX) ? sync_q[1] : level_q;
    end
  end
  assign level_o = level_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: two-button hours/minutes setter with blink, idle timeout (AUTOREPEAT_EN adds held-inc repeat)
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int HALF_SEC     = DEF_HALF_SEC,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int TIMEOUT_S    = DEF_TIMEOUT_S
) (
  input logic clk,
  input logic rst_n,
  clock_set_ctrl_if.slave bus
);
  localparam int HW = $clog2(HALF_SEC + 1);
  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam logic [HW-1:0] HMAX = HW'(HALF_SEC);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT_S - 1);
  logic mode_lvl, inc_lvl, mode_prev_q, inc_prev_q;
  logic mode_ev, inc_raw, inc_ev, any_ev, rep_ev, edit, half_wrap, sec_tick, timeout;
  state_e state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [IW-1:0] idle_q, idle_d;
  logic phase_q, phase_d;
  hours_t hours_q, hours_d;
  minutes_t minutes_q, minutes_d;
  logic hold_q, hold_d, load_q, load_d;
  logic [3:0] blank_q, blank_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_mode), .level_o(mode_lvl));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_db (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_inc), .level_o(inc_lvl));

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(4 * (HALF_SEC + 1));
  localparam logic [RW-1:0] REP_FIRST  = RW'(4 * (HALF_SEC + 1) - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(3 * (HALF_SEC + 1));
  logic [RW-1:0] rep_q, rep_d;
  // first repeat after 2 s of held inc, then reload so each further one is half a second apart
  always_comb begin
    rep_ev = edit && inc_lvl && rep_q == REP_FIRST;
    rep_d  = (!edit || !inc_lvl) ? '0 : rep_ev ? REP_RELOAD : rep_q + 1'b1;
  end
  // repeat-interval counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_ev = 1'b0;
`endif

  // event decode, blink/idle timing and edit state next values
  always_comb begin
    mode_ev   = mode_lvl & ~mode_prev_q;
    inc_raw   = (inc_lvl & ~inc_prev_q) | rep_ev;
    inc_ev    = inc_raw & ~mode_ev;
    any_ev    = mode_ev | inc_raw;
    edit      = state_q == SET_HR || state_q == SET_MIN;
    half_wrap = half_q == HMAX;
    half_d    = (any_ev || half_wrap) ? '0 : half_q + 1'b1;
    phase_d   = any_ev ? 1'b0 : half_wrap ? ~phase_q : phase_q;
    sec_tick  = !any_ev && half_wrap && phase_q;
    timeout   = edit && sec_tick && idle_q == TMAX;
    idle_d    = (!edit || any_ev) ? '0 : sec_tick ? idle_q + 1'b1 : idle_q;
    case (state_q)
      RUN:     state_d = mode_ev ? SET_HR : RUN;
      SET_HR:  state_d = timeout ? RUN : mode_ev ? SET_MIN : SET_HR;
      SET_MIN: state_d = timeout ? RUN : mode_ev ? COMMIT : SET_MIN;
      default: state_d = RUN;
    endcase
    hours_d   = (state_q == RUN && mode_ev) ? bus.cur_hours :
                (state_q == SET_HR && inc_ev) ? 5'(wrap_inc({1'b0, hours_q}, {1'b0, HOURS_MAX})) : hours_q;
    minutes_d = (state_q == RUN && mode_ev) ? bus.cur_minutes :
                (state_q == SET_MIN && inc_ev) ? wrap_inc(minutes_q, MINUTES_MAX) : minutes_q;
    hold_d    = state_d != RUN;
    load_d    = state_d == COMMIT;
    blank_d   = (state_d == SET_HR) ? {phase_d, phase_d, 2'b00} :
                (state_d == SET_MIN) ? {2'b00, phase_d, phase_d} : 4'b0000;
  end

  // FSM, timers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      half_q      <= '0;
      idle_q      <= '0;
      phase_q     <= 1'b0;
      hours_q     <= '0;
      minutes_q   <= '0;
      hold_q      <= 1'b0;
      load_q      <= 1'b0;
      blank_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_lvl;
      inc_prev_q  <= inc_lvl;
      half_q      <= half_d;
      idle_q      <= idle_d;
      phase_q     <= phase_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      hold_q      <= hold_d;
      load_q      <= load_d;
      blank_q     <= blank_d;
    end
  end

  assign bus.hold        = hold_q;
  assign bus.load        = load_q;
  assign bus.new_hours   = hours_q;
  assign bus.new_minutes = minutes_q;
  assign bus.digit_blank = blank_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for the clock setter (HALF_SEC=9, DEBOUNCE_CYC=4, TIMEOUT_S=3)
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  int load_cnt = 0;
  logic after_load = 1'b0;
  logic [10:0] exp_q[$];
  clock_set_ctrl_if bus();

  clock_set_ctrl #(.HALF_SEC(9), .DEBOUNCE_CYC(4), .TIMEOUT_S(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic press(input bit inc, input int hi);
    if (inc) bus.btn_inc = 1'b1; else bus.btn_mode = 1'b1;
    repeat (hi) @(negedge clk);
    bus.btn_inc = 1'b0;
    bus.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // scoreboard: each load pulse pops the expected time; hold must drop the cycle after
  always @(negedge clk) begin
    if (!rst_n) after_load <= 1'b0;
    else if (bus.load) begin
      load_cnt++;
      chk("hold_at_load", bus.hold, 1);
      if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
      else chk("load_value", {bus.new_hours, bus.new_minutes}, exp_q.pop_front());
      after_load <= 1'b1;
    end else if (after_load) begin
      chk("hold_after_load", bus.hold, 0);
      after_load <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, lat;
    logic seen;
    bus.btn_mode = 1'b0;
    bus.btn_inc = 1'b0;
    bus.cur_hours = 5'd23;
    bus.cur_minutes = 6'd58;
    repeat (3) @(negedge clk);
    chk("rst_hold", bus.hold, 0);
    chk("rst_load", bus.load, 0);
    chk("rst_hours", bus.new_hours, 0);
    chk("rst_minutes", bus.new_minutes, 0);
    chk("rst_blank", bus.digit_blank, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // glitch shorter than the debounce window
    bus.btn_mode = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_mode = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= bus.hold;
    end
    chk("glitch_hold", seen, 0);
    // full edit from 23:58 to 00:00
    press(0, 10);
    chk("edit_hold", bus.hold, 1);
    chk("edit_cap_h", bus.new_hours, 23);
    chk("edit_cap_m", bus.new_minutes, 58);
    press(1, 10);
    chk("hours_wrap", bus.new_hours, 0);
    press(0, 10);
    chk("min_hold", bus.hold, 1);
    press(1, 10);
    chk("min_59", bus.new_minutes, 59);
    press(1, 10);
    chk("min_wrap", bus.new_minutes, 0);
    chk("min_wrap_h", bus.new_hours, 0);
    exp_q.push_back({5'd0, 6'd0});
    press(0, 10);
    chk("edit_done_hold", bus.hold, 0);
    // minute wrap from 59 with a long inc hold that must count once
    bus.cur_hours = 5'd5;
    bus.cur_minutes = 6'd59;
    press(0, 10);
    press(0, 10);
    chk("wrap_start", bus.new_minutes, 59);
    press(1, 45);
    chk("wrap_min", bus.new_minutes, 0);
    chk("wrap_hours", bus.new_hours, 5);
    exp_q.push_back({5'd5, 6'd0});
    press(0, 10);
    // idle timeout in SET_HR
    bus.cur_hours = 5'd10;
    bus.cur_minutes = 6'd20;
    press(0, 10);
    repeat (40) @(negedge clk);
    chk("to_before", bus.hold, 1);
    repeat (15) @(negedge clk);
    chk("to_after", bus.hold, 0);
    chk("to_blank", bus.digit_blank, 0);
    // blink in SET_HR, aligned to the press that enters it
    bus.btn_mode = 1'b1;
    n = 0;
    while (!bus.hold && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("enter_hr_bound", n < 30, 1);
    lat = n;
    bus.btn_mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("blink_hr_0", bus.digit_blank, 4'b0000);
    repeat (10) @(negedge clk);
    chk("blink_hr_1", bus.digit_blank, 4'b1100);
    repeat (10) @(negedge clk);
    chk("blink_hr_2", bus.digit_blank, 4'b0000);
    repeat (10) @(negedge clk);
    chk("blink_hr_3", bus.digit_blank, 4'b1100);
    bus.btn_mode = 1'b1;
    repeat (lat) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("blink_min_0", bus.digit_blank, 4'b0000);
    repeat (10) @(negedge clk);
    chk("blink_min_1", bus.digit_blank, 4'b0011);
    repeat (10) @(negedge clk);
    chk("blink_min_2", bus.digit_blank, 4'b0000);
    repeat (10) @(negedge clk);
    chk("blink_min_3", bus.digit_blank, 4'b0011);
    repeat (15) @(negedge clk);
    chk("to_min_before", bus.hold, 1);
    repeat (15) @(negedge clk);
    chk("to_min_after", bus.hold, 0);
    // reset while editing minutes
    press(0, 10);
    press(0, 10);
    chk("pre_rst_blank", bus.digit_blank, 4'b0011);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hold", bus.hold, 0);
    chk("mid_rst_blank", bus.digit_blank, 0);
    chk("mid_rst_min", bus.new_minutes, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_hold", bus.hold, 0);
    chk("load_count", load_cnt, 2);
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
